// File: rtl/irq_pending_latch_if.sv
// Request/acknowledge bus between the interrupt capture stage and its consumer.
// The capture stage takes the slave view; the consumer (or bench) the master view.
interface irq_pending_latch_if;
  logic [3:0] irq_in;
  logic       mask_wr;
  logic [3:0] mask_din;
  logic [3:0] req_vec;
  logic       irq_out;
  logic       ack;
  logic [1:0] ack_idx;
  logic       ack_err;
  logic [3:0] ovf;
  logic       clr_ovf;

  modport master (
    output irq_in, mask_wr, mask_din, ack, ack_idx, clr_ovf,
    input  req_vec, irq_out, ack_err, ovf
  );

  modport slave (
    input  irq_in, mask_wr, mask_din, ack, ack_idx, clr_ovf,
    output req_vec, irq_out, ack_err, ovf
  );
endinterface

// File: rtl/irq_pending_latch.sv
// Interrupt capture ahead of the 4-to-2 priority encoder: synchronise, detect
// events, latch pending, mask, and hand requests to the consumer with ack/clear.
module irq_pending_latch #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [3:0] EDGE_MODE   = 4'b1111,
  parameter logic [3:0] MASK_RST    = 4'b0000
) (
  input logic                clk,
  input logic                rst,
  irq_pending_latch_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  logic [3:0] sync_p [SYNC_STAGES];
  logic [3:0] sync_q;
  logic [3:0] prev_p;
  logic [3:0] rise;
  logic [3:0] pending;
  logic [3:0] pending_nxt;
  logic [3:0] mask;
  logic [3:0] ovf;
  logic [3:0] ovf_set;
  logic [3:0] clr;
  logic [3:0] req;
  logic       valid_ack;
  logic       ack_err;
  logic       irq_out;
  state_t     state;

  // Synchroniser chain; prev_p is one extra stage used only for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
      prev_p <= '0;
    end else begin
      sync_p[0] <= bus.irq_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
      prev_p <= sync_q;
    end
  end

  assign sync_q = sync_p[SYNC_STAGES-1];
  assign rise   = sync_q & ~prev_p;
  assign req    = pending & mask;

  assign valid_ack = bus.ack && (state == REQ) && req[bus.ack_idx];

  // Only edge-latched sources are cleared by an acknowledge.
  always_comb begin
    clr = '0;
    if (valid_ack) clr[bus.ack_idx] = EDGE_MODE[bus.ack_idx];
  end

  assign pending_nxt = (EDGE_MODE & (rise | (pending & ~clr))) | (~EDGE_MODE & sync_q);
  assign ovf_set     = rise & pending & ~clr;

  // Pending, mask, overflow and error state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      mask    <= MASK_RST;
      ovf     <= '0;
      ack_err <= 1'b0;
    end else begin
      pending <= pending_nxt;
      if (bus.mask_wr) mask <= bus.mask_din;
      ovf     <= (bus.clr_ovf ? 4'b0000 : ovf) | ovf_set;
      ack_err <= bus.ack && !valid_ack;
    end
  end

  // Request handshake; HOLD keeps irq_out low one cycle while the encoder settles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      irq_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req != 4'b0000) begin
            state   <= REQ;
            irq_out <= 1'b1;
          end
        end
        REQ: begin
          if (valid_ack) begin
            state   <= HOLD;
            irq_out <= 1'b0;
          end else if (req == 4'b0000) begin
            state   <= IDLE;
            irq_out <= 1'b0;
          end
        end
        HOLD: begin
          state   <= IDLE;
          irq_out <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          irq_out <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_vec = req;
  assign bus.irq_out = irq_out;
  assign bus.ack_err = ack_err;
  assign bus.ovf     = ovf;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Bench for irq_pending_latch: directed scenarios on an all-edge and a mixed
// edge/level instance, then random traffic against a cycle reference model.
module tb_irq_pending_latch;

  localparam int SS = 2;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  irq_pending_latch_if ifa ();
  irq_pending_latch_if ifb ();

  irq_pending_latch #(.SYNC_STAGES(SS), .EDGE_MODE(4'b1111), .MASK_RST(4'b0000)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  irq_pending_latch #(.SYNC_STAGES(SS), .EDGE_MODE(4'b1110), .MASK_RST(4'b0000)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: input history, pending set, and a "request outstanding /
  // cool-down" view of the handshake derived from the service rules.
  typedef struct packed {
    logic [SS:0][3:0] hist;
    logic [3:0]       pend;
    logic [3:0]       msk;
    logic [3:0]       ovf;
    logic             err;
    logic             busy;
    logic             cool;
  } mdl_t;

  mdl_t ma;
  mdl_t mb;

  function automatic mdl_t mstep(input mdl_t s, input logic [3:0] em, input logic [3:0] irq,
                                 input logic mwr, input logic [3:0] mdin, input logic ack,
                                 input logic [1:0] idx, input logic cov);
    mdl_t n;
    logic [3:0] sq, pv, rq, rs, cl;
    logic valid;
    n  = s;
    sq = s.hist[SS-1];
    pv = s.hist[SS];
    rq = s.pend & s.msk;
    rs = sq & ~pv;
    valid = ack && s.busy && rq[idx];
    cl = 4'b0000;
    if (valid && em[idx]) cl = 4'b0001 << idx;
    n.hist = {s.hist[SS-1:0], irq};
    n.pend = (em & (rs | (s.pend & ~cl))) | (~em & sq);
    n.ovf  = (cov ? 4'b0000 : s.ovf) | (rs & s.pend & ~cl);
    n.err  = ack && !valid;
    if (mwr) n.msk = mdin;
    if (s.busy) begin
      n.busy = !(valid || (rq == 4'b0000));
      n.cool = valid;
    end else if (s.cool) begin
      n.cool = 1'b0;
    end else begin
      n.busy = (rq != 4'b0000);
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma <= '0;
      mb <= '0;
    end else begin
      ma <= mstep(ma, 4'b1111, ifa.irq_in, ifa.mask_wr, ifa.mask_din, ifa.ack, ifa.ack_idx, ifa.clr_ovf);
      mb <= mstep(mb, 4'b1110, ifb.irq_in, ifb.mask_wr, ifb.mask_din, ifb.ack, ifb.ack_idx, ifb.clr_ovf);
    end
  end

  function automatic logic [9:0] mexp(input mdl_t m);
    return {m.pend & m.msk, m.busy, m.err, m.ovf};
  endfunction

  // Observed vector layout: {req_vec, irq_out, ack_err, ovf}
  function automatic logic [9:0] obs_a();
    return {ifa.req_vec, ifa.irq_out, ifa.ack_err, ifa.ovf};
  endfunction

  function automatic logic [9:0] obs_b();
    return {ifb.req_vec, ifb.irq_out, ifb.ack_err, ifb.ovf};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_inputs();
    ifa.irq_in = '0; ifa.mask_wr = 1'b0; ifa.mask_din = '0; ifa.ack = 1'b0; ifa.ack_idx = '0; ifa.clr_ovf = 1'b0;
    ifb.irq_in = '0; ifb.mask_wr = 1'b0; ifb.mask_din = '0; ifb.ack = 1'b0; ifb.ack_idx = '0; ifb.clr_ovf = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (obs_a() !== 10'b0) begin errors++; $display("FAIL rst_a act=%b exp=%b", obs_a(), 10'b0); end
    checks++; if (obs_b() !== 10'b0) begin errors++; $display("FAIL rst_b act=%b exp=%b", obs_b(), 10'b0); end
  endtask

  task automatic test_single();
    ifa.mask_wr = 1'b1; ifa.mask_din = 4'b1111; cyc(1); ifa.mask_wr = 1'b0;
    cyc($urandom_range(0, 3));
    ifa.irq_in = 4'b0100; cyc(1); ifa.irq_in = 4'b0000;
    cyc(1);
    checks++; if (obs_a() !== 10'b0) begin errors++; $display("FAIL t1_early act=%b exp=%b", obs_a(), 10'b0); end
    cyc(1);
    checks++; if (obs_a() !== {4'b0100, 1'b0, 1'b0, 4'b0}) begin errors++; $display("FAIL t1_req act=%b exp=%b", obs_a(), {4'b0100, 1'b0, 1'b0, 4'b0}); end
    cyc(1);
    checks++; if (obs_a() !== {4'b0100, 1'b1, 1'b0, 4'b0}) begin errors++; $display("FAIL t1_irq act=%b exp=%b", obs_a(), {4'b0100, 1'b1, 1'b0, 4'b0}); end
    ifa.ack = 1'b1; ifa.ack_idx = 2'd2; cyc(1); ifa.ack = 1'b0;
    checks++; if (obs_a() !== 10'b0) begin errors++; $display("FAIL t1_hold act=%b exp=%b", obs_a(), 10'b0); end
    cyc(1);
    checks++; if (obs_a() !== 10'b0) begin errors++; $display("FAIL t1_idle act=%b exp=%b", obs_a(), 10'b0); end
  endtask

  task automatic test_back_to_back();
    cyc($urandom_range(0, 3));
    ifa.irq_in = 4'b1001; cyc(1); ifa.irq_in = 4'b0000;
    cyc(2);
    checks++; if (obs_a() !== {4'b1001, 1'b0, 1'b0, 4'b0}) begin errors++; $display("FAIL t2_req act=%b exp=%b", obs_a(), {4'b1001, 1'b0, 1'b0, 4'b0}); end
    cyc(1);
    checks++; if (obs_a() !== {4'b1001, 1'b1, 1'b0, 4'b0}) begin errors++; $display("FAIL t2_irq act=%b exp=%b", obs_a(), {4'b1001, 1'b1, 1'b0, 4'b0}); end
    ifa.ack = 1'b1; ifa.ack_idx = 2'd3; cyc(1); ifa.ack = 1'b0;
    checks++; if (obs_a() !== {4'b0001, 1'b0, 1'b0, 4'b0}) begin errors++; $display("FAIL t2_hold act=%b exp=%b", obs_a(), {4'b0001, 1'b0, 1'b0, 4'b0}); end
    cyc(1);
    checks++; if (obs_a() !== {4'b0001, 1'b0, 1'b0, 4'b0}) begin errors++; $display("FAIL t2_gap act=%b exp=%b", obs_a(), {4'b0001, 1'b0, 1'b0, 4'b0}); end
    cyc(1);
    checks++; if (obs_a() !== {4'b0001, 1'b1, 1'b0, 4'b0}) begin errors++; $display("FAIL t2_rereq act=%b exp=%b", obs_a(), {4'b0001, 1'b1, 1'b0, 4'b0}); end
    ifa.ack = 1'b1; ifa.ack_idx = 2'd0; cyc(1); ifa.ack = 1'b0;
    checks++; if (obs_a() !== 10'b0) begin errors++; $display("FAIL t2_done act=%b exp=%b", obs_a(), 10'b0); end
    cyc(2);
  endtask

  task automatic test_overflow();
    ifa.irq_in = 4'b0010; cyc(1); ifa.irq_in = 4'b0000; cyc(1);
    ifa.irq_in = 4'b0010; cyc(1); ifa.irq_in = 4'b0000; cyc(1);
    checks++; if (obs_a() !== {4'b0010, 1'b1, 1'b0, 4'b0000}) begin errors++; $display("FAIL t3_pre act=%b exp=%b", obs_a(), {4'b0010, 1'b1, 1'b0, 4'b0000}); end
    cyc(1);
    checks++; if (obs_a() !== {4'b0010, 1'b1, 1'b0, 4'b0010}) begin errors++; $display("FAIL t3_ovf act=%b exp=%b", obs_a(), {4'b0010, 1'b1, 1'b0, 4'b0010}); end
    ifa.clr_ovf = 1'b1; cyc(1); ifa.clr_ovf = 1'b0;
    checks++; if (obs_a() !== {4'b0010, 1'b1, 1'b0, 4'b0000}) begin errors++; $display("FAIL t3_clr act=%b exp=%b", obs_a(), {4'b0010, 1'b1, 1'b0, 4'b0000}); end
    ifa.ack = 1'b1; ifa.ack_idx = 2'd1; cyc(1); ifa.ack = 1'b0;
    checks++; if (obs_a() !== 10'b0) begin errors++; $display("FAIL t3_ack act=%b exp=%b", obs_a(), 10'b0); end
    cyc(2);
  endtask

  task automatic test_mask();
    ifa.mask_wr = 1'b1; ifa.mask_din = 4'b0000; cyc(1); ifa.mask_wr = 1'b0;
    ifa.irq_in = 4'b0100; cyc(1); ifa.irq_in = 4'b0000;
    cyc(4);
    checks++; if (obs_a() !== 10'b0) begin errors++; $display("FAIL t4_hidden act=%b exp=%b", obs_a(), 10'b0); end
    ifa.mask_wr = 1'b1; ifa.mask_din = 4'b0100; cyc(1); ifa.mask_wr = 1'b0;
    checks++; if (obs_a() !== {4'b0100, 1'b0, 1'b0, 4'b0}) begin errors++; $display("FAIL t4_unmask act=%b exp=%b", obs_a(), {4'b0100, 1'b0, 1'b0, 4'b0}); end
    cyc(1);
    checks++; if (obs_a() !== {4'b0100, 1'b1, 1'b0, 4'b0}) begin errors++; $display("FAIL t4_irq act=%b exp=%b", obs_a(), {4'b0100, 1'b1, 1'b0, 4'b0}); end
    ifa.ack = 1'b1; ifa.ack_idx = 2'd2; cyc(1); ifa.ack = 1'b0;
    ifa.mask_wr = 1'b1; ifa.mask_din = 4'b1111; cyc(1); ifa.mask_wr = 1'b0;
    cyc(1);
  endtask

  task automatic test_level();
    ifb.mask_wr = 1'b1; ifb.mask_din = 4'b1111; cyc(1); ifb.mask_wr = 1'b0;
    ifb.irq_in = 4'b0001; cyc(4);
    checks++; if (obs_b() !== {4'b0001, 1'b1, 1'b0, 4'b0}) begin errors++; $display("FAIL t5_irq act=%b exp=%b", obs_b(), {4'b0001, 1'b1, 1'b0, 4'b0}); end
    ifb.ack = 1'b1; ifb.ack_idx = 2'd0; cyc(1); ifb.ack = 1'b0;
    checks++; if (obs_b() !== {4'b0001, 1'b0, 1'b0, 4'b0}) begin errors++; $display("FAIL t5_hold act=%b exp=%b", obs_b(), {4'b0001, 1'b0, 1'b0, 4'b0}); end
    cyc(2);
    checks++; if (obs_b() !== {4'b0001, 1'b1, 1'b0, 4'b0}) begin errors++; $display("FAIL t5_rereq act=%b exp=%b", obs_b(), {4'b0001, 1'b1, 1'b0, 4'b0}); end
    ifb.irq_in = 4'b0000; cyc(3);
    checks++; if (obs_b() !== {4'b0000, 1'b1, 1'b0, 4'b0}) begin errors++; $display("FAIL t5_drop act=%b exp=%b", obs_b(), {4'b0000, 1'b1, 1'b0, 4'b0}); end
    cyc(1);
    checks++; if (obs_b() !== 10'b0) begin errors++; $display("FAIL t5_fall act=%b exp=%b", obs_b(), 10'b0); end
  endtask

  task automatic test_ack_err();
    ifa.irq_in = 4'b1000; cyc(1); ifa.irq_in = 4'b0000; cyc(3);
    checks++; if (obs_a() !== {4'b1000, 1'b1, 1'b0, 4'b0}) begin errors++; $display("FAIL t6_req act=%b exp=%b", obs_a(), {4'b1000, 1'b1, 1'b0, 4'b0}); end
    ifa.ack = 1'b1; ifa.ack_idx = 2'd1; cyc(1); ifa.ack = 1'b0;
    checks++; if (obs_a() !== {4'b1000, 1'b1, 1'b1, 4'b0}) begin errors++; $display("FAIL t6_badidx act=%b exp=%b", obs_a(), {4'b1000, 1'b1, 1'b1, 4'b0}); end
    cyc(1);
    checks++; if (obs_a() !== {4'b1000, 1'b1, 1'b0, 4'b0}) begin errors++; $display("FAIL t6_pulse act=%b exp=%b", obs_a(), {4'b1000, 1'b1, 1'b0, 4'b0}); end
    ifa.ack = 1'b1; ifa.ack_idx = 2'd3; cyc(1); ifa.ack = 1'b0;
    cyc(1);
    ifa.ack = 1'b1; ifa.ack_idx = 2'd3; cyc(1); ifa.ack = 1'b0;
    checks++; if (obs_a() !== {4'b0000, 1'b0, 1'b1, 4'b0}) begin errors++; $display("FAIL t6_idleack act=%b exp=%b", obs_a(), {4'b0000, 1'b0, 1'b1, 4'b0}); end
    cyc(1);
  endtask

  task automatic test_reset_mid();
    ifa.irq_in = 4'b1000; cyc(1); ifa.irq_in = 4'b0000; cyc(1);
    ifa.irq_in = 4'b1000; cyc(1); ifa.irq_in = 4'b0000; cyc(2);
    checks++; if (obs_a() !== {4'b1000, 1'b1, 1'b0, 4'b1000}) begin errors++; $display("FAIL t7_pre act=%b exp=%b", obs_a(), {4'b1000, 1'b1, 1'b0, 4'b1000}); end
    #2 rst = 1'b1;
    #1;
    checks++; if (obs_a() !== 10'b0) begin errors++; $display("FAIL t7_async act=%b exp=%b", obs_a(), 10'b0); end
    cyc(1);
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic test_random();
    do_reset();
    ifa.mask_wr = 1'b1; ifa.mask_din = 4'b1111;
    ifb.mask_wr = 1'b1; ifb.mask_din = 4'b1111;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      checks++; if (obs_a() !== mexp(ma)) begin errors++; $display("FAIL rnd_a cyc=%0d act=%b exp=%b", c, obs_a(), mexp(ma)); end
      checks++; if (obs_b() !== mexp(mb)) begin errors++; $display("FAIL rnd_b cyc=%0d act=%b exp=%b", c, obs_b(), mexp(mb)); end
      ifa.irq_in   = ifa.irq_in ^ ((($urandom % 4) == 0) ? 4'($urandom) : 4'b0000);
      ifb.irq_in   = ifb.irq_in ^ ((($urandom % 4) == 0) ? 4'($urandom) : 4'b0000);
      ifa.mask_wr  = (($urandom % 16) == 0);
      ifb.mask_wr  = (($urandom % 16) == 0);
      ifa.mask_din = (($urandom % 2) == 0) ? 4'b1111 : 4'($urandom);
      ifb.mask_din = (($urandom % 2) == 0) ? 4'b1111 : 4'($urandom);
      ifa.ack      = (($urandom % 3) == 0);
      ifb.ack      = (($urandom % 3) == 0);
      ifa.ack_idx  = 2'($urandom);
      ifb.ack_idx  = 2'($urandom);
      ifa.clr_ovf  = (($urandom % 20) == 0);
      ifb.clr_ovf  = (($urandom % 20) == 0);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_mask();
    test_level();
    test_ack_err();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/irq_pending_latch.md
Name: irq_pending_latch

Overview:
- Upstream request-capture stage for the 4-to-2 priority encoder built from two 2-to-1 encoders.
- Synchronises four asynchronous interrupt lines, detects events and latches them as pending, applies a software mask, and drives the 4-bit request vector into the encoder.
- Runs a request/acknowledge handshake with the consumer, which returns the encoded index to clear the serviced source.
- Bit 3 is highest priority; the encoder maps in[3]→2'b11 and in[0]→2'b00.

Parameters:
- SYNC_STAGES, 2, synchroniser depth per input line; legal values 2..3.
- EDGE_MODE, 4'b1111, per-bit mode: 1 = rising-edge latched, 0 = level (follows synchronised input).
- MASK_RST, 4'b0000, mask register value after reset; 1 = enabled.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- irq_in  input  4  asynchronous interrupt lines.
- mask_wr  input  1  write strobe for mask register.
- mask_din  input  4  new mask value.
- req_vec  output  4  pending & mask; drives the encoder input.
- irq_out  output  1  registered request to consumer.
- ack  input  1  consumer acknowledge, one-cycle pulse.
- ack_idx  input  2  index being serviced (encoder output echoed back).
- ack_err  output  1  one-cycle pulse when an acknowledge is invalid.
- ovf  output  4  sticky overflow per source.
- clr_ovf  input  1  clears all ovf bits.

Behaviour:
- Reset values:
  - sync flops, pending, ovf, irq_out and ack_err all 0.
  - mask = MASK_RST.
  - FSM in IDLE.
- Synchroniser: SYNC_STAGES flops per bit; sync_q is the last stage.
- Edge detect: rise[i] = sync_q[i] & ~prev[i], where prev is one further flop.
  - A line already high at reset release counts as a rising edge.
- Pending, edge bits: set on rise[i]; cleared on a valid ack with ack_idx==i. If set and clear coincide, set wins.
- Pending, level bits: pending[i] = sync_q[i] every cycle; ack never clears them.
- Overflow: ovf[i] is set when rise[i] occurs while pending[i]=1 and no valid clear of bit i happens in the same cycle.
  - Sticky until clr_ovf.
  - If clr_ovf and a new overflow coincide, set wins.
- req_vec = pending & mask; combinational from registers, no input-to-output path.
- Mask: mask_wr loads mask_din at the clock edge. Masking hides a bit but does not clear its pending flag.
- Latency (SYNC_STAGES=2):
  - irq_in rises before edge n; pending is visible after edge n+2.
  - req_vec is visible after edge n+2; irq_out rises after edge n+3.
- FSM states:
  - IDLE: irq_out=0. Go to REQ when req_vec != 0.
  - REQ: irq_out=1.
    - On ack with a valid index: clear per rules above, go to HOLD.
    - If req_vec becomes 0 without an ack (masked or level drop): go to IDLE, irq_out falls next cycle.
  - HOLD: irq_out=0 for exactly one cycle so the encoder output settles; then go to IDLE.
- Valid ack: ack=1, FSM in REQ, and req_vec[ack_idx]=1.
- Invalid ack: ack in IDLE or HOLD, or req_vec[ack_idx]=0. Effect: ack_err pulses 1 the next cycle; no state or pending change.
- Acking a level-mode bit is valid: FSM goes to HOLD, pending is unchanged. If the line is still high, the FSM re-requests from IDLE.
- Back-to-back service: minimum period is REQ→HOLD→IDLE→REQ, so irq_out has at least 2 low cycles between requests.
- Reset asserted mid-operation: all state clears immediately (asynchronous); events in flight are lost.

Test Plan:
1. Reset, mask=4'b1111, pulse irq_in[2] for 1 cycle → req_vec=4'b0100 two edges after sampling, irq_out=1 one edge later; ack with idx=2 → req_vec=0, irq_out=0, FSM passes through HOLD, no ack_err.
2. Raise irq_in[0] and irq_in[3] in the same cycle → req_vec=4'b1001; ack idx=3 → req_vec=4'b0001; irq_out re-asserts after HOLD+IDLE; ack idx=0 → req_vec=0.
3. Pulse irq_in[1] twice with no ack between → ovf=4'b0010 after the second edge is detected; clr_ovf → ovf=0; pending[1] remains 1.
4. mask=4'b0000, pulse irq_in[2] → req_vec=0, irq_out stays 0; write mask=4'b0100 → req_vec=4'b0100 next cycle, irq_out=1 the cycle after.
5. EDGE_MODE=4'b1110, hold irq_in[0] high → irq_out=1; ack idx=0 → HOLD then re-request, irq_out=1 again; drop line → req_vec=0, irq_out falls.
6. With req_vec=4'b1000 send ack idx=1 → ack_err pulses 1, pending unchanged; ack while in IDLE → ack_err=1. Assert rst mid-REQ → req_vec, irq_out and ovf all 0 immediately.
